// File: rtl/data_memory.sv
// Word-organised data memory for the MEM stage of the pipelined MIPS CPU.
// Combinational reads, synchronous word stores, asynchronous clear of the whole array.
`timescale 1ns/1ps

module data_memory #(
    parameter int DEPTH     = 3072,
    parameter int ADDR_LSB  = 2,
    parameter int IDX_WIDTH = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] Data,
    input  logic        MemWrite,
    output logic [31:0] MemData
);

    localparam int IDX_MSB = IDX_WIDTH + ADDR_LSB - 1;

    logic [31:0]          mem [DEPTH];
    logic [IDX_WIDTH-1:0] index;
    logic                 in_range;

    assign index = Address[IDX_MSB:ADDR_LSB];

    // Upper address bits must be clear and the index below DEPTH; indices never wrap.
    assign in_range = (Address[31:IDX_MSB+1] == '0) &&
                      ({{(32-IDX_WIDTH){1'b0}}, index} < 32'(DEPTH));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (MemWrite == 1'b1 && in_range) begin
            mem[index] <= Data;
        end
    end

    // Reads are gated by reset so MemData drops to zero the moment reset rises.
    assign MemData = (!reset && in_range) ? mem[index] : 32'h0;

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed scenarios plus random traffic
// compared against a word-array reference model addressed by byte address.
`timescale 1ns/1ps

module tb_data_memory;

    logic        clk;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] Data;
    logic        MemWrite;
    logic [31:0] MemData;

    int tests;
    int failed;

    logic [31:0] model [3072];

    data_memory dut (
        .clk      (clk),
        .reset    (reset),
        .Address  (Address),
        .Data     (Data),
        .MemWrite (MemWrite),
        .MemData  (MemData)
    );

    initial begin
        clk = 1'b0;
        forever #1 clk = ~clk;
    end

    function automatic logic [31:0] modelRead(input logic [31:0] addr);
        if (addr < 32'h3000) return model[addr / 4];
        return 32'h0;
    endfunction

    task automatic modelClear();
        for (int i = 0; i < 3072; i++) model[i] = 32'h0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] expected);
        tests++;
        assert (MemData === expected)
        else begin
            failed++;
            $error("[TB] FAIL %s: observed %h expected %h (addr %h)", tag, MemData, expected, Address);
        end
    endtask

    // Called just after a falling edge; drives one access, checks before and
    // after the rising edge, and returns positioned at the next falling edge.
    task automatic applyStimulus(input string tag, input logic [31:0] addr,
                                 input logic [31:0] data, input logic we);
        Address  = addr;
        Data     = data;
        MemWrite = we;
        #0.5;
        checkOutput({tag, "_pre"}, modelRead(addr));
        @(posedge clk);
        if (we && addr < 32'h3000) model[addr / 4] = data;
        #0.5;
        checkOutput({tag, "_post"}, modelRead(addr));
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic        w;
        tests  = 0;
        failed = 0;
        modelClear();

        // Reset held across the first edge with a write pending.
        reset    = 1'b1;
        MemWrite = 1'b1;
        Address  = 32'h0;
        Data     = 32'h1;
        #0.5;
        checkOutput("reset_read0", 32'h0);
        @(posedge clk);
        #0.5;
        checkOutput("reset_edge_read0", 32'h0);
        Address = 32'h100;
        #0.1;
        checkOutput("reset_read100", 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Sweep: word k written with k+1.
        for (int k = 0; k < 64; k++) begin
            applyStimulus("sweep_wr", 32'(k * 4), 32'(k + 1), 1'b1);
        end
        for (int k = 0; k < 64; k++) begin
            applyStimulus("sweep_rd", 32'(k * 4), 32'hDEADBEEF, 1'b0);
            checkOutput("sweep_const", 32'(k + 1));
        end

        // Read-during-write.
        applyStimulus("rdw_init", 32'h10, 32'h12345678, 1'b1);
        Address  = 32'h10;
        Data     = 32'hCAFEBABE;
        MemWrite = 1'b1;
        #0.5;
        checkOutput("rdw_before", 32'h12345678);
        @(posedge clk);
        model[4] = 32'hCAFEBABE;
        #0.5;
        checkOutput("rdw_after", 32'hCAFEBABE);
        @(negedge clk);

        // Unaligned and out-of-range.
        applyStimulus("unaligned_wr", 32'h2FFD, 32'hAAAA5555, 1'b1);
        applyStimulus("unaligned_rd", 32'h2FFC, 32'h0, 1'b0);
        checkOutput("word_bff", 32'hAAAA5555);
        applyStimulus("oor_wr", 32'h3000, 32'h11111111, 1'b1);
        checkOutput("oor_read0", 32'h0);
        applyStimulus("oor_hi_wr", 32'h8000_0010, 32'h22222222, 1'b1);
        checkOutput("oor_hi_read0", 32'h0);
        applyStimulus("word0_rd", 32'h0, 32'h0, 1'b0);
        checkOutput("word0_kept", 32'h1);
        applyStimulus("alias_rd", 32'h10, 32'h0, 1'b0);
        checkOutput("alias_kept", 32'hCAFEBABE);

        // MemWrite low keeps the word.
        applyStimulus("mw_init", 32'h20, 32'h5A5A_A5A5, 1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus("mw_low", 32'h20, 32'hFFFFFFFF, 1'b0);
            checkOutput("mw_low_const", 32'h5A5A_A5A5);
        end

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            a = 32'($urandom_range(0, 32'h3FFF));
            if ($urandom_range(0, 7) == 0) a = a | ($urandom & 32'hFFFF_C000);
            d = $urandom;
            w = 1'($urandom_range(0, 1));
            applyStimulus("rand", a, d, w);
        end

        // Asynchronous reset pulse between edges.
        applyStimulus("async_w0", 32'h0, 32'h0BAD_F00D, 1'b1);
        applyStimulus("async_w4", 32'h4, 32'h1357_9BDF, 1'b1);
        Address  = 32'h4;
        MemWrite = 1'b0;
        #0.2;
        checkOutput("async_before", 32'h1357_9BDF);
        reset = 1'b1;
        #0.1;
        checkOutput("async_drop", 32'h0);
        #0.1;
        reset = 1'b0;
        modelClear();
        #0.1;
        checkOutput("async_after4", 32'h0);
        @(negedge clk);
        applyStimulus("async_rd0", 32'h0, 32'h0, 1'b0);
        checkOutput("async_word0", 32'h0);
        applyStimulus("async_rd4", 32'h4, 32'h0, 1'b0);
        checkOutput("async_word4", 32'h0);

        // Reset and write asserted together across an edge.
        reset    = 1'b1;
        Address  = 32'h40;
        Data     = 32'hDEAD_0040;
        MemWrite = 1'b1;
        @(posedge clk);
        #0.5;
        checkOutput("rvw_during", 32'h0);
        @(negedge clk);
        reset    = 1'b0;
        MemWrite = 1'b0;
        modelClear();
        #0.5;
        checkOutput("rvw_after", 32'h0);
        @(negedge clk);
        applyStimulus("post_reset_wr", 32'h40, 32'h4040_4040, 1'b1);
        applyStimulus("post_reset_rd", 32'h40, 32'h0, 1'b0);
        checkOutput("post_reset_const", 32'h4040_4040);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
